// File: rtl/mem_stage_pkg.sv
// MEM stage shared constants.
// Access FSM encodings and the write-back read-data default.
package mem_stage_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [31:0] WB_RDATA_DEFAULT = 32'h0;

endpackage

// File: rtl/mem_stage_dmem_access_fsm.sv
// Data-memory access sequencer for a variable-latency memory.
// Holds the request until ack or until the wait budget runs out.
module dmem_access_fsm
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_op,
  input  logic misaligned,
  input  logic dmem_ack,
  output logic req,
  output logic stall,
  output logic done,
  output logic timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    req      = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    timeout  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (mem_op && !misaligned) begin
          req = 1'b1;
          if (dmem_ack) begin
            done = 1'b1;
          end else begin
            stall    = 1'b1;
            state_nx = ST_WAIT;
            cnt_nx   = CW'(1);
          end
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        // ack wins over an expiring budget in the same cycle
        if (dmem_ack) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt == CW'(TIMEOUT)) begin
          timeout  = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          stall  = 1'b1;
          cnt_nx = cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: EX/MEM capture, branch resolution,
// data-memory access with stall, and the MEM/WB register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB_PC   = 32,
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_ADDR = 10,
  parameter int TIMEOUT = 16
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_MEM_valid,
  input  logic               i_MEM_flush,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_mem_read,
  input  logic               i_MEM_mem_write,
  input  logic               i_MEM_branch,
  input  logic [NB_PC-1:0]   i_MEM_branch_addr,
  input  logic               i_MEM_zero,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_DATA-1:0] i_MEM_store_data,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  output logic               o_MEM_stall,
  output logic               o_MEM_pc_src,
  output logic [NB_PC-1:0]   o_MEM_branch_addr,
  output logic               o_MEM_error,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [NB_ADDR-1:0] o_dmem_addr,
  output logic [NB_DATA-1:0] o_dmem_wdata,
  input  logic               i_dmem_ack,
  input  logic [NB_DATA-1:0] i_dmem_rdata,
  output logic               o_WB_valid,
  output logic               o_WB_reg_write,
  output logic               o_WB_mem_to_reg,
  output logic [NB_DATA-1:0] o_WB_read_data,
  output logic [NB_DATA-1:0] o_WB_alu_result,
  output logic [NB_REG-1:0]  o_WB_selected_reg
);

  logic               em_valid;
  logic               em_reg_write;
  logic               em_mem_to_reg;
  logic               em_mem_read;
  logic               em_mem_write;
  logic               em_branch;
  logic               em_zero;
  logic [NB_PC-1:0]   em_branch_addr;
  logic [NB_DATA-1:0] em_alu_result;
  logic [NB_DATA-1:0] em_store_data;
  logic [NB_REG-1:0]  em_selected_reg;

  logic mem_op;
  logic misaligned;
  logic is_load;
  logic stall;
  logic done;
  logic timeout;
  logic wb_reg_write;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      em_valid        <= 1'b0;
      em_reg_write    <= 1'b0;
      em_mem_to_reg   <= 1'b0;
      em_mem_read     <= 1'b0;
      em_mem_write    <= 1'b0;
      em_branch       <= 1'b0;
      em_zero         <= 1'b0;
      em_branch_addr  <= '0;
      em_alu_result   <= '0;
      em_store_data   <= '0;
      em_selected_reg <= '0;
    end else if (!stall) begin
      em_valid        <= i_MEM_valid & ~i_MEM_flush;
      em_reg_write    <= i_MEM_reg_write;
      em_mem_to_reg   <= i_MEM_mem_to_reg;
      em_mem_read     <= i_MEM_mem_read;
      em_mem_write    <= i_MEM_mem_write;
      em_branch       <= i_MEM_branch;
      em_zero         <= i_MEM_zero;
      em_branch_addr  <= i_MEM_branch_addr;
      em_alu_result   <= i_MEM_alu_result;
      em_store_data   <= i_MEM_store_data;
      em_selected_reg <= i_MEM_selected_reg;
    end
  end

  assign mem_op     = em_valid & (em_mem_read | em_mem_write);
  assign misaligned = mem_op & (em_alu_result[1:0] != 2'b00);
  // read+write together behaves as a store
  assign is_load    = em_mem_read & ~em_mem_write;

  dmem_access_fsm #(
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk        (i_clock),
    .rst_n      (i_reset_n),
    .mem_op     (mem_op),
    .misaligned (misaligned),
    .dmem_ack   (i_dmem_ack),
    .req        (o_dmem_req),
    .stall      (stall),
    .done       (done),
    .timeout    (timeout)
  );

  assign o_MEM_stall       = stall;
  assign o_MEM_pc_src      = em_valid & em_branch & em_zero;
  assign o_MEM_branch_addr = em_branch_addr;
  assign o_dmem_we         = em_mem_write;
  assign o_dmem_addr       = em_alu_result[NB_ADDR+1:2];
  assign o_dmem_wdata      = em_store_data;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_WB_valid        <= 1'b0;
      wb_reg_write      <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_read_data    <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
    end else if (stall) begin
      o_WB_valid        <= 1'b0;
      wb_reg_write      <= 1'b0;
      o_WB_mem_to_reg   <= 1'b0;
      o_WB_read_data    <= '0;
      o_WB_alu_result   <= '0;
      o_WB_selected_reg <= '0;
    end else begin
      o_WB_valid        <= em_valid;
      wb_reg_write      <= em_reg_write & ~misaligned & ~timeout;
      o_WB_mem_to_reg   <= em_mem_to_reg;
      o_WB_read_data    <= (is_load & done) ? i_dmem_rdata
                                            : NB_DATA'(WB_RDATA_DEFAULT);
      o_WB_alu_result   <= em_alu_result;
      o_WB_selected_reg <= em_selected_reg;
    end
  end

  assign o_WB_reg_write = o_WB_valid & wb_reg_write;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_MEM_error <= 1'b0;
    end else if (misaligned | timeout) begin
      o_MEM_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vectors,
// multi-cycle corner sequences and a randomized scoreboard run.
module tb_mem_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_flush, in_rw, in_m2r;
  logic        in_rd, in_wr, in_br, in_zero;
  logic [31:0] in_baddr, in_alu, in_sdata;
  logic [4:0]  in_reg;
  logic        stall, pc_src, err, req, we, ack;
  logic [31:0] baddr_o, wdata, rdata;
  logic [9:0]  addr;
  logic        wb_valid, wb_rw, wb_m2r;
  logic [31:0] wb_rdata, wb_alu;
  logic [4:0]  wb_reg;

  int checks = 0;
  int failures = 0;

  mem_stage dut (
    .i_clock            (clk),
    .i_reset_n          (rst_n),
    .i_MEM_valid        (in_valid),
    .i_MEM_flush        (in_flush),
    .i_MEM_reg_write    (in_rw),
    .i_MEM_mem_to_reg   (in_m2r),
    .i_MEM_mem_read     (in_rd),
    .i_MEM_mem_write    (in_wr),
    .i_MEM_branch       (in_br),
    .i_MEM_branch_addr  (in_baddr),
    .i_MEM_zero         (in_zero),
    .i_MEM_alu_result   (in_alu),
    .i_MEM_store_data   (in_sdata),
    .i_MEM_selected_reg (in_reg),
    .o_MEM_stall        (stall),
    .o_MEM_pc_src       (pc_src),
    .o_MEM_branch_addr  (baddr_o),
    .o_MEM_error        (err),
    .o_dmem_req         (req),
    .o_dmem_we          (we),
    .o_dmem_addr        (addr),
    .o_dmem_wdata       (wdata),
    .i_dmem_ack         (ack),
    .i_dmem_rdata       (rdata),
    .o_WB_valid         (wb_valid),
    .o_WB_reg_write     (wb_rw),
    .o_WB_mem_to_reg    (wb_m2r),
    .o_WB_read_data     (wb_rdata),
    .o_WB_alu_result    (wb_alu),
    .o_WB_selected_reg  (wb_reg)
  );

  typedef struct {
    bit        valid, flush, rw, m2r, rd, wr, br, zero;
    bit [31:0] baddr, alu, sdata;
    bit [4:0]  rg;
  } bundle_t;

  typedef struct {
    bundle_t   b;
    bit        ack;
    bit [31:0] bus;
    bit        e_pc, e_req, e_we, e_wbv, e_wbrw;
    bit [31:0] e_rdata;
    bit        e_err;
  } vec_t;

  typedef struct {
    bit        rw, m2r;
    bit [31:0] rdata, alu;
    bit [4:0]  rg;
  } wb_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bundle_t mkb(bit v, bit f, bit rw, bit m2r,
                                  bit rd, bit wr, bit br, bit z,
                                  bit [31:0] ba, bit [31:0] alu,
                                  bit [31:0] sd, bit [4:0] rg);
    bundle_t b;
    b.valid = v;  b.flush = f; b.rw = rw;  b.m2r = m2r;
    b.rd = rd;    b.wr = wr;   b.br = br;  b.zero = z;
    b.baddr = ba; b.alu = alu; b.sdata = sd; b.rg = rg;
    return b;
  endfunction

  function automatic bundle_t bubble();
    return mkb(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t b = bubble();
    int k = $urandom_range(0, 4);
    b.valid = ($urandom_range(0, 9) != 0);
    b.flush = ($urandom_range(0, 9) == 0);
    b.rw    = 1'($urandom);
    b.rg    = 5'($urandom);
    b.sdata = $urandom;
    b.alu   = $urandom;
    if (k == 2) begin
      b.br    = 1'b1;
      b.zero  = 1'($urandom);
      b.baddr = $urandom;
    end else if (k == 3) begin
      b.rd  = 1'b1;
      b.m2r = 1'b1;
      b.alu = $urandom & 32'hFFFF_F03C;
    end else if (k == 4) begin
      b.wr  = 1'b1;
      b.rd  = ($urandom_range(0, 3) == 0);
      b.alu = $urandom & 32'hFFFF_F03C;
    end
    return b;
  endfunction

  task automatic drive(bundle_t b);
    in_valid = b.valid; in_flush = b.flush; in_rw = b.rw;
    in_m2r = b.m2r; in_rd = b.rd; in_wr = b.wr; in_br = b.br;
    in_zero = b.zero; in_baddr = b.baddr; in_alu = b.alu;
    in_sdata = b.sdata; in_reg = b.rg;
  endtask

  task automatic reset_dut(string tag);
    drive(bubble());
    ack = 1'b0;
    rdata = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, " rst req"}, req, 0);
    chk({tag, " rst stall"}, stall, 0);
    chk({tag, " rst wb_valid"}, wb_valid, 0);
    chk({tag, " rst err"}, err, 0);
    chk({tag, " rst pc_src"}, pc_src, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t    vt[10];
  bundle_t b, b2, cur, pend;
  wb_t     exp_q[$];
  wb_t     e;
  bit [31:0] ref_mem[1024];
  bit [31:0] dev_mem[1024];
  int nreq, nstall, lat, waited;
  bit need_drive, exp_req, exp_stall;

  initial begin
    drive(bubble());
    ack = 1'b0;
    rdata = '0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i] = '0;
      dev_mem[i] = '0;
    end

    vt[0] = '{mkb(1,0,1,0,0,0,0,0,0,32'h10,0,5), 0, 0,
              0, 0, 0, 1, 1, 32'h0, 0};
    vt[1] = '{mkb(1,0,0,0,0,0,1,1,32'h80,32'h0,0,0), 0, 0,
              1, 0, 0, 1, 0, 32'h0, 0};
    vt[2] = '{mkb(1,0,0,0,0,0,1,0,32'h84,32'h1,0,0), 0, 0,
              0, 0, 0, 1, 0, 32'h0, 0};
    vt[3] = '{mkb(1,1,1,0,0,0,1,1,32'h88,32'h20,0,6), 0, 0,
              0, 0, 0, 0, 0, 32'h0, 0};
    vt[4] = '{mkb(1,0,1,1,1,0,0,0,0,32'h40,0,8), 1, 32'h12345678,
              0, 1, 0, 1, 1, 32'h12345678, 0};
    vt[5] = '{mkb(1,0,0,0,0,1,0,0,0,32'h44,32'hDEADBEEF,0), 1, 32'h55,
              0, 1, 1, 1, 0, 32'h0, 0};
    vt[6] = '{mkb(1,0,1,1,1,1,0,0,0,32'h48,32'h0BADF00D,9), 1, 32'h77,
              0, 1, 1, 1, 1, 32'h0, 0};
    vt[7] = '{mkb(1,0,1,0,0,0,0,0,0,32'h4C,0,10), 1, 32'hFFFF,
              0, 0, 0, 1, 1, 32'h0, 0};
    vt[8] = '{mkb(0,0,1,1,1,0,0,0,0,32'h50,0,11), 1, 32'h99,
              0, 0, 0, 0, 0, 32'h0, 0};
    vt[9] = '{mkb(1,0,1,0,0,1,0,0,0,32'h42,32'h1,12), 1, 32'h0,
              0, 0, 0, 1, 0, 32'h0, 1};

    reset_dut("init");

    for (int i = 0; i < 10; i++) begin
      drive(vt[i].b);
      @(posedge clk); #1;
      ack = vt[i].ack;
      rdata = vt[i].bus;
      drive(bubble());
      #1;
      chk($sformatf("v%0d pc_src", i), pc_src, vt[i].e_pc);
      chk($sformatf("v%0d req", i), req, vt[i].e_req);
      chk($sformatf("v%0d stall", i), stall, 0);
      chk($sformatf("v%0d baddr", i), baddr_o, vt[i].b.baddr);
      if (vt[i].e_req) begin
        chk($sformatf("v%0d addr", i), addr, vt[i].b.alu[11:2]);
        chk($sformatf("v%0d we", i), we, vt[i].e_we);
      end
      @(posedge clk); #1;
      ack = 1'b0;
      chk($sformatf("v%0d wb_valid", i), wb_valid, vt[i].e_wbv);
      chk($sformatf("v%0d wb_rw", i), wb_rw, vt[i].e_wbrw);
      chk($sformatf("v%0d wb_rdata", i), wb_rdata, vt[i].e_rdata);
      chk($sformatf("v%0d err", i), err, vt[i].e_err);
      chk($sformatf("v%0d pc_src off", i), pc_src, 0);
      if (vt[i].e_wbv) begin
        chk($sformatf("v%0d wb_alu", i), wb_alu, vt[i].b.alu);
        chk($sformatf("v%0d wb_reg", i), wb_reg, vt[i].b.rg);
      end
    end
    chk("err sticky", err, 1);

    // three-cycle load with an ALU op queued behind it
    reset_dut("seqA");
    drive(mkb(1,0,1,1,1,0,0,0,0,32'h40,0,7));
    @(posedge clk); #1;
    drive(mkb(1,0,1,0,0,0,0,0,0,32'h99,0,9));
    nreq = 0;
    nstall = 0;
    for (int c = 0; c < 3; c++) begin
      ack = (c == 2);
      rdata = 32'hCAFEBABE;
      #1;
      if (req) nreq++;
      if (stall) nstall++;
      if (c == 0) chk("A addr", addr, 10'h010);
      if (c == 1) chk("A wb bubble", wb_valid, 0);
      @(posedge clk); #1;
    end
    ack = 1'b0;
    drive(bubble());
    chk("A req cycles", nreq, 3);
    chk("A stall cycles", nstall, 2);
    chk("A wb_valid", wb_valid, 1);
    chk("A wb_rdata", wb_rdata, 32'hCAFEBABE);
    chk("A wb_reg", wb_reg, 7);
    chk("A req drop", req, 0);
    @(posedge clk); #1;
    chk("A next wb_reg", wb_reg, 9);
    chk("A next wb_alu", wb_alu, 32'h99);
    chk("A next wb_rdata", wb_rdata, 0);
    @(posedge clk); #1;
    chk("A held once", wb_valid, 0);

    // load that never gets an ack
    drive(mkb(1,0,1,1,1,0,0,0,0,32'h80,0,3));
    @(posedge clk); #1;
    drive(bubble());
    nstall = 0;
    for (int c = 0; c < 40; c++) begin
      if (!stall) break;
      nstall++;
      @(posedge clk); #1;
    end
    chk("B stall cycles", nstall, 16);
    chk("B err before", err, 0);
    @(posedge clk); #1;
    chk("B err", err, 1);
    chk("B wb_valid", wb_valid, 1);
    chk("B wb_rdata", wb_rdata, 0);
    chk("B wb_rw", wb_rw, 0);
    chk("B idle req", req, 0);
    chk("B idle stall", stall, 0);

    // reset asserted while waiting on memory
    drive(mkb(1,0,1,1,1,0,0,0,0,32'h20,0,2));
    @(posedge clk); #1;
    drive(bubble());
    @(posedge clk); #1;
    chk("C waiting", stall, 1);
    rst_n = 1'b0;
    #1;
    chk("C rst req", req, 0);
    chk("C rst stall", stall, 0);
    chk("C rst err", err, 0);
    chk("C rst wb_valid", wb_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mkb(1,1,1,0,0,0,0,0,0,32'h30,0,4));
    @(posedge clk); #1;
    drive(bubble());
    @(posedge clk); #1;
    chk("C flush wb_valid", wb_valid, 0);
    chk("C flush wb_rw", wb_rw, 0);
    chk("C after req", req, 0);

    // randomized run against the transaction-level scoreboard
    reset_dut("rnd");
    @(posedge clk); #1;
    cur = bubble();
    pend = rand_bundle();
    need_drive = 1'b1;
    waited = 0;
    lat = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (need_drive) begin
        drive(pend);
        need_drive = 1'b0;
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rnd wb unexpected actual=1 required=0");
        end else begin
          e = exp_q.pop_front();
          chk("rnd wb rdata", wb_rdata, e.rdata);
          chk("rnd wb alu", wb_alu, e.alu);
          chk("rnd wb ctl", {wb_rw, wb_m2r, wb_reg}, {e.rw, e.m2r, e.rg});
        end
      end
      chk("rnd pc_src", pc_src, cur.valid & cur.br & cur.zero);
      if (cur.valid && cur.br) chk("rnd baddr", baddr_o, cur.baddr);
      exp_req = cur.valid && (cur.rd || cur.wr);
      chk("rnd req", req, exp_req);
      if (exp_req) begin
        chk("rnd addr", addr, cur.alu[11:2]);
        if (waited == lat) begin
          ack = 1'b1;
          if (we) begin
            dev_mem[addr] = wdata;
            rdata = $urandom;
          end else begin
            rdata = dev_mem[addr];
          end
        end else begin
          ack = 1'b0;
          rdata = $urandom;
        end
        waited++;
      end else begin
        ack = ($urandom_range(0, 3) == 0);
        rdata = $urandom;
      end
      exp_stall = exp_req && !ack;
      #1;
      chk("rnd stall", stall, exp_stall);
      if (!exp_stall) begin
        in_flush = pend.flush;
        if (pend.valid && !pend.flush) begin
          cur = pend;
          e.rw = pend.rw;
          e.m2r = pend.m2r;
          e.alu = pend.alu;
          e.rg = pend.rg;
          e.rdata = '0;
          if (pend.wr)
            ref_mem[pend.alu[11:2]] = pend.sdata;
          else if (pend.rd)
            e.rdata = ref_mem[pend.alu[11:2]];
          exp_q.push_back(e);
        end else begin
          cur = bubble();
        end
        waited = 0;
        lat = $urandom_range(0, 3);
        pend = (cyc < 560) ? rand_bundle() : bubble();
        need_drive = 1'b1;
      end else begin
        in_flush = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    chk("rnd drained", exp_q.size(), 0);
    chk("rnd err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage. It is the consumer of the EX stage's output bundle.
- Contains the EX/MEM capture register and branch resolution (pc_src).
- Drives a data-memory request/ack port for a memory with variable latency.
- Contains the MEM/WB register feeding write-back, and raises a stall to freeze upstream stages while an access is pending.

Parameters:
- NB_PC, 32, PC / branch target width
- NB_DATA, 32, data path width
- NB_REG, 5, register index width
- NB_ADDR, 10, data-memory word address width
- TIMEOUT, 16, max wait cycles for i_dmem_ack before error

Ports:
- i_clock  in  1  single clock; all state on rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_MEM_valid  in  1  EX bundle holds a real instruction
- i_MEM_flush  in  1  turn the incoming bundle into a bubble
- i_MEM_reg_write  in  1  WB flag
- i_MEM_mem_to_reg  in  1  WB flag
- i_MEM_mem_read  in  1  load
- i_MEM_mem_write  in  1  store
- i_MEM_branch  in  1  conditional branch
- i_MEM_branch_addr  in  NB_PC  branch target
- i_MEM_zero  in  1  ALU zero
- i_MEM_alu_result  in  NB_DATA  ALU result / byte address
- i_MEM_store_data  in  NB_DATA  store data
- i_MEM_selected_reg  in  NB_REG  destination register
- o_MEM_stall  out  1  freeze PC/IF/ID/EX
- o_MEM_pc_src  out  1  take branch
- o_MEM_branch_addr  out  NB_PC  registered branch target
- o_MEM_error  out  1  sticky: misaligned access or timeout
- o_dmem_req  out  1  access request
- o_dmem_we  out  1  1 = write
- o_dmem_addr  out  NB_ADDR  word address = alu_result[NB_ADDR+1:2]
- o_dmem_wdata  out  NB_DATA  store data
- i_dmem_ack  in  1  access complete this cycle
- i_dmem_rdata  in  NB_DATA  read data, valid with ack
- o_WB_valid  out  1  MEM/WB holds an instruction
- o_WB_reg_write  out  1  forced 0 when !o_WB_valid
- o_WB_mem_to_reg  out  1
- o_WB_read_data  out  NB_DATA
- o_WB_alu_result  out  NB_DATA
- o_WB_selected_reg  out  NB_REG

Behaviour:
- Reset (async, i_reset_n=0):
  - All registers and outputs clear to 0, FSM goes to IDLE, wait counter clears to 0.
  - o_dmem_req drops immediately, including mid-access.
  - Any pending access is abandoned; no WB is produced for it.
- EX/MEM capture:
  - When !o_MEM_stall, the register loads the bundle on the clock edge.
  - Its valid bit loads i_MEM_valid & !i_MEM_flush.
  - When o_MEM_stall=1, the register holds and i_MEM_flush is ignored.
- Branch:
  - o_MEM_pc_src = em_valid & em_branch & em_zero, combinational from the EX/MEM register. Asserted for exactly one cycle.
  - Branch instructions never stall.
- mem_op = em_valid & (em_mem_read | em_mem_write).
- mem_read and mem_write both set: treated as a write.
- Misaligned access (alu_result[1:0] != 0 with mem_op):
  - No request is issued, o_MEM_error is set, and the instruction retires to WB with reg_write forced to 0.
  - No stall.
- FSM, states IDLE and WAIT:
  - IDLE with aligned mem_op: o_dmem_req=1.
    - If i_dmem_ack is high in the same cycle, the access completes with no stall.
    - Otherwise o_MEM_stall=1 and the FSM moves to WAIT with counter=1.
  - WAIT: o_dmem_req=1 and o_MEM_stall=1; the counter increments each cycle.
    - On ack: stall=0 that cycle, MEM/WB captures i_dmem_rdata, FSM returns to IDLE, counter clears.
    - If the counter reaches TIMEOUT without ack: the access completes with read data 0 and reg_write forced to 0, o_MEM_error is set, FSM returns to IDLE.
  - Req/addr/we/wdata stay stable while req=1.
  - An ack with no req is ignored.
- MEM/WB capture:
  - Loads every cycle stall=0. Valid = em_valid.
  - A stall cycle loads a bubble (valid=0).
  - o_WB_read_data is the captured rdata, or 0 for non-loads.
- Latency:
  - Bundle accepted at edge N; WB outputs visible after edge N+1 (zero-wait).
  - Each extra wait cycle adds one cycle.
- Throughput: one instruction per cycle when ack is same-cycle.
- o_MEM_error clears only on reset.

Decomposition:
- Shared constants include file: FSM state encodings (ST_IDLE, ST_WAIT) and the WB read-data default.
- One sub-module, dmem_access_fsm: FSM plus timeout counter.
  - Inputs: mem_op, misaligned, i_dmem_ack.
  - Outputs: req, stall, done, timeout.
- Pipeline registers and branch logic stay in mem_stage.

Test Plan:
- ALU op: valid=1, reg_write=1, alu_result=0x00000010, reg=5, ack unused -> after 2 edges o_WB_valid=1, o_WB_alu_result=0x10, o_WB_selected_reg=5, no req, stall never 1.
- Load, 3-cycle memory: mem_read, addr byte 0x40 -> o_dmem_addr=0x010, req high 3 cycles, stall high 2 cycles, ack with rdata=0xCAFEBABE -> next cycle o_WB_read_data=0xCAFEBABE; EX bundle held during stall is captured once afterwards.
- Branch: branch=1, zero=1, branch_addr=0x00000080 -> o_MEM_pc_src=1 for one cycle, o_MEM_branch_addr=0x80; with zero=0 -> pc_src stays 0.
- Store misaligned: mem_write, alu_result=0x00000042 -> no req, o_MEM_error=1 sticky, o_WB_reg_write=0.
- Timeout: load, ack never -> stall for TIMEOUT=16 cycles, then o_MEM_error=1, o_WB_read_data=0, o_WB_reg_write=0, FSM back to IDLE.
- Reset mid-WAIT: drop i_reset_n during stall -> req, stall and all outputs 0 immediately; after release, a flush+valid bundle yields o_WB_valid=0.
